// File: rtl/band_gain_mixer_pkg.sv
// -----------------------------------------------------------------------------
// eq_pkg : shared definitions for the band gain mixer slice.
//
// Contents
//   state_t      sequencing states of the mixer (IDLE, MAC, OUT)
//   DEF_POT_W    default pot reading width
//   UNITY_SHIFT  right shift that maps a unity gain code back to 1.0
//                (gain code 1 << (POT_W-2) is unity, full scale is ~4x)
//   sat()        clamps a wide signed value to a signed range of 'width' bits
// -----------------------------------------------------------------------------
package eq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int DEF_POT_W   = 12;
    localparam int UNITY_SHIFT = DEF_POT_W - 2;

    // Clamp 'value' to [-2^(width-1), 2^(width-1)-1]. The result is returned
    // sign-extended to 64 bits; callers keep the low 'width' bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                               input int width);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (width - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (width - 1));
        if (value > hi) begin
            return hi;
        end else if (value < lo) begin
            return lo;
        end
        return value;
    endfunction

endpackage

// File: rtl/band_gain_mixer_taper.sv
// -----------------------------------------------------------------------------
// gain_taper : quadratic pot taper plus optional per-frame gain slew limiter.
//
// Purely combinational. The mixer instantiates it once and feeds it the pot
// (and current gain) of the band being processed this cycle.
//
// Ports
//   pot   in   POT_W  unsigned pot reading
//   cur   in   POT_W  gain currently applied to this band (GAIN_SMOOTH_EN only)
//   gain  out  POT_W  gain to use for this band this frame
//
// Build option
//   GAIN_SMOOTH_EN  defined  : gain = cur moved toward the target by at most STEP
//                   undefined: gain = target (changes take effect immediately)
// -----------------------------------------------------------------------------
module gain_taper
    import eq_pkg::*;
#(
    parameter int POT_W = DEF_POT_W,
    parameter int STEP  = 256
) (
    input  logic [POT_W-1:0] pot,
`ifdef GAIN_SMOOTH_EN
    input  logic [POT_W-1:0] cur,
`endif
    output logic [POT_W-1:0] gain
);

    logic [POT_W-1:0] tgt;

    // Square law taper: keep the upper POT_W bits of pot*pot.
    always_comb begin
        tgt = POT_W'(((2*POT_W)'(pot) * (2*POT_W)'(pot)) >> POT_W);
    end

`ifdef GAIN_SMOOTH_EN
    logic [31:0] diff;
    logic [31:0] move;

    always_comb begin
        diff = '0;
        move = '0;
        gain = cur;
        if (tgt > cur) begin
            diff = 32'(tgt) - 32'(cur);
            move = (diff > 32'(STEP)) ? 32'(STEP) : diff;
            gain = POT_W'(32'(cur) + move);
        end else if (tgt < cur) begin
            diff = 32'(cur) - 32'(tgt);
            move = (diff > 32'(STEP)) ? 32'(STEP) : diff;
            gain = POT_W'(32'(cur) - move);
        end
    end
`else
    always_comb begin
        gain = tgt;
    end
`endif

endmodule

// File: rtl/band_gain_mixer.sv
// -----------------------------------------------------------------------------
// band_gain_mixer : applies a pot-controlled gain to each of N_BANDS band
// samples of a frame, saturates each band, sums them and saturates the sum.
// One multiplier is shared; a small FSM steps through the bands.
//
// Ports
//   clk         in   1               system clock
//   rst_n       in   1               asynchronous active-low reset
//   in_vld      in   1               frame strobe, accepted when in_rdy=1
//   in_rdy      out  1               high only while IDLE
//   in_samples  in   N_BANDS*DATA_W  packed signed samples, band 0 in LSBs
//   pots        in   N_BANDS*POT_W   packed unsigned pots, band 0 in LSBs
//   out_vld     out  1               one-cycle pulse, out_sample updated
//   out_sample  out  DATA_W          saturated mix, held until next frame
//   overrun     out  1               one-cycle pulse: in_vld seen while busy
//   dbg_state   out  2               current FSM state (eq_pkg::state_t)
//
// Handshake: a frame transfers on a rising edge where in_vld=1 and in_rdy=1.
// in_vld while in_rdy=0 is dropped and reported on overrun the next cycle;
// the frame in flight is not disturbed. out_vld has no back-pressure.
//
// Timing: frame accepted at edge k, bands processed at edges k+1..k+N_BANDS,
// result registered at edge k+N_BANDS+1. One frame per N_BANDS+2 cycles.
//
// Build option: GAIN_SMOOTH_EN enables per-band gain slew limiting (see
// gain_taper); otherwise the target gain is applied directly.
// -----------------------------------------------------------------------------
module band_gain_mixer
    import eq_pkg::*;
#(
    parameter int N_BANDS = 4,
    parameter int DATA_W  = 16,
    parameter int POT_W   = DEF_POT_W,
    parameter int STEP    = 256
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_vld,
    output logic                        in_rdy,
    input  logic [N_BANDS*DATA_W-1:0]   in_samples,
    input  logic [N_BANDS*POT_W-1:0]    pots,
    output logic                        out_vld,
    output logic signed [DATA_W-1:0]    out_sample,
    output logic                        overrun,
    output logic [1:0]                  dbg_state
);

    localparam int BW    = $clog2(N_BANDS);
    localparam int ACC_W = DATA_W + $clog2(N_BANDS);
    localparam int PW    = DATA_W + POT_W + 1;
    localparam int SHIFT = POT_W - 2;

    state_t                      state_q, state_d;
    logic [BW-1:0]               band_q;
    logic [N_BANDS*DATA_W-1:0]   samp_q;
    logic [N_BANDS*POT_W-1:0]    pots_q;
    logic signed [ACC_W-1:0]     acc_q;

    logic                        last_band;
    logic [POT_W-1:0]            cur_pot;
    logic signed [DATA_W-1:0]    cur_samp;
    logic [POT_W-1:0]            gain;
    logic signed [PW-1:0]        prod;
    logic signed [DATA_W-1:0]    band_val;
    logic signed [DATA_W-1:0]    acc_sat;

`ifdef GAIN_SMOOTH_EN
    logic [POT_W-1:0]            cur_gain [N_BANDS];
`endif

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_vld)    state_d = MAC;
            MAC:     if (last_band) state_d = OUT;
            OUT:                    state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    assign in_rdy    = (state_q == IDLE);
    assign dbg_state = state_q;
    assign last_band = (band_q == BW'(N_BANDS - 1));

    // ---------------- band datapath ----------------
    always_comb begin
        cur_pot  = pots_q[int'(band_q) * POT_W +: POT_W];
        cur_samp = $signed(samp_q[int'(band_q) * DATA_W +: DATA_W]);
    end

    gain_taper #(
        .POT_W (POT_W),
        .STEP  (STEP)
    ) u_taper (
        .pot  (cur_pot),
`ifdef GAIN_SMOOTH_EN
        .cur  (cur_gain[band_q]),
`endif
        .gain (gain)
    );

    // Gain is treated as a positive signed number so the product keeps the
    // sample's sign; >>> floors toward -inf.
    always_comb begin
        prod     = PW'(cur_samp) * PW'($signed({1'b0, gain}));
        band_val = DATA_W'(sat(64'(prod >>> SHIFT), DATA_W));
        acc_sat  = DATA_W'(sat(64'(acc_q), DATA_W));
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            band_q     <= '0;
            samp_q     <= '0;
            pots_q     <= '0;
            acc_q      <= '0;
            out_vld    <= 1'b0;
            out_sample <= '0;
            overrun    <= 1'b0;
`ifdef GAIN_SMOOTH_EN
            for (int i = 0; i < N_BANDS; i++) begin
                cur_gain[i] <= '0;
            end
`endif
        end else begin
            out_vld <= 1'b0;
            overrun <= in_vld && (state_q != IDLE);
            case (state_q)
                IDLE: begin
                    if (in_vld) begin
                        samp_q <= in_samples;
                        pots_q <= pots;
                        acc_q  <= '0;
                        band_q <= '0;
                    end
                end
                MAC: begin
                    // Accumulator is wide enough for N_BANDS saturated bands.
                    acc_q  <= acc_q + ACC_W'(band_val);
                    band_q <= band_q + BW'(1);
`ifdef GAIN_SMOOTH_EN
                    cur_gain[band_q] <= gain;
`endif
                end
                OUT: begin
                    out_vld    <= 1'b1;
                    out_sample <= acc_sat;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_band_gain_mixer.sv
// -----------------------------------------------------------------------------
// tb_band_gain_mixer : self-checking bench for band_gain_mixer (4 bands,
// 16-bit samples, 12-bit pots). Expected values come from fixed vector
// tables and from a plain-arithmetic reference model of the mixing rules.
// -----------------------------------------------------------------------------
module tb_band_gain_mixer;

    localparam int NB = 4;
    localparam int DW = 16;
    localparam int PWD = 12;

    logic                   clk;
    logic                   rst_n;
    logic                   in_vld;
    logic                   in_rdy;
    logic [NB*DW-1:0]       in_samples;
    logic [NB*PWD-1:0]      pots;
    logic                   out_vld;
    logic signed [DW-1:0]   out_sample;
    logic                   overrun;
    logic [1:0]             dbg_state;

    band_gain_mixer #(
        .N_BANDS (NB),
        .DATA_W  (DW),
        .POT_W   (PWD),
        .STEP    (256)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_vld     (in_vld),
        .in_rdy     (in_rdy),
        .in_samples (in_samples),
        .pots       (pots),
        .out_vld    (out_vld),
        .out_sample (out_sample),
        .overrun    (overrun),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_bad = 0;
    logic [DW-1:0] exp_q[$];
    longint cur_m [NB];

    typedef struct {
        longint s [NB];
        longint p [NB];
        longint exp_v;
    } vec_t;

    task automatic check(input string name, input longint act, input longint exp_v);
        n_vec++;
        if (act != exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, exp_v);
        end
    endtask

    function automatic longint clamp16(input longint v);
        if (v > 32767) return 32767;
        if (v < -32768) return -32768;
        return v;
    endfunction

    // Reference model: one frame of the mixing rules; updates cur_m.
    function automatic longint model_frame(input longint s [NB], input longint p [NB]);
        longint sum, tgt, g, v;
        sum = 0;
        for (int b = 0; b < NB; b++) begin
            tgt = (p[b] * p[b]) / 4096;
`ifdef GAIN_SMOOTH_EN
            if (tgt > cur_m[b])      g = cur_m[b] + ((tgt - cur_m[b] > 256) ? 256 : tgt - cur_m[b]);
            else if (tgt < cur_m[b]) g = cur_m[b] - ((cur_m[b] - tgt > 256) ? 256 : cur_m[b] - tgt);
            else                     g = cur_m[b];
`else
            g = tgt;
`endif
            cur_m[b] = g;
            v = s[b] * g;
            // floor division by 1024
            v = (v >= 0) ? v / 1024 : -((-v + 1023) / 1024);
            sum += clamp16(v);
        end
        return clamp16(sum);
    endfunction

    function automatic logic [NB*DW-1:0] pack_s(input longint s [NB]);
        logic [NB*DW-1:0] r;
        longint t;
        for (int b = 0; b < NB; b++) begin
            t = s[b];
            r[b*DW +: DW] = t[DW-1:0];
        end
        return r;
    endfunction

    function automatic logic [NB*PWD-1:0] pack_p(input longint p [NB]);
        logic [NB*PWD-1:0] r;
        longint t;
        for (int b = 0; b < NB; b++) begin
            t = p[b];
            r[b*PWD +: PWD] = t[PWD-1:0];
        end
        return r;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int cnt;
        cnt = 0;
        while (!in_rdy && cnt < 50) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!in_rdy) begin
            n_vec++; n_bad++;
            $display("FAIL ready_timeout: got in_rdy=0 required 1");
        end
    endtask

    // Sends one frame and checks latency and result against expv.
    task automatic send_frame(input longint s [NB], input longint p [NB],
                              input logic [DW-1:0] expv, input string name);
        bit got;
        wait_ready();
        in_samples = pack_s(s);
        pots       = pack_p(p);
        in_vld     = 1'b1;
        exp_q.push_back(expv);
        got = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (c == 1) in_vld = 1'b0;
            if (out_vld) begin
                got = 1;
                check({name, "_latency"}, c, NB + 2);
                break;
            end
        end
        if (!got) begin
            void'(exp_q.pop_front());
            n_vec++; n_bad++;
            $display("FAIL %s_timeout: got no out_vld required pulse", name);
        end else begin
            check(name, $signed(out_sample), $signed(exp_q.pop_front()));
        end
    endtask

    // Frame with an extra in_vld injected 'inj' cycles after acceptance.
    task automatic overrun_frame(input int inj, input string name);
        longint s [NB], p [NB], bad_s [NB], bad_p [NB], ev;
        int vld_at, extra;
        s = '{3000, -700, 1200, 50};
        p = '{2048, 3000, 1500, 4095};
        bad_s = '{30000, 30000, 30000, 30000};
        bad_p = '{4095, 4095, 4095, 4095};
        ev = model_frame(s, p);
        wait_ready();
        in_samples = pack_s(s);
        pots       = pack_p(p);
        in_vld     = 1'b1;
        vld_at = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            in_vld = 1'b0;
            if (out_vld && vld_at == 0) begin
                vld_at = c;
                check({name, "_result"}, $signed(out_sample), ev);
            end
            if (c == inj + 1) check({name, "_overrun_hi"}, overrun, 1);
            if (c == inj + 2) check({name, "_overrun_lo"}, overrun, 0);
            if (c == inj) begin
                check({name, "_busy"}, in_rdy, 0);
                in_samples = pack_s(bad_s);
                pots       = pack_p(bad_p);
                in_vld     = 1'b1;
            end
        end
        check({name, "_latency"}, vld_at, NB + 2);
        extra = 0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_vld) extra++;
        end
        check({name, "_dropped"}, extra, 0);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int b = 0; b < NB; b++) cur_m[b] = 0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // ---------------- test sequence ----------------
    vec_t vecs [$];

    initial begin
        vec_t v;
        longint s [NB], p [NB];
        longint ev;
        int pulses;
        logic [15:0] r;

        rst_n = 1'b0;
        in_vld = 1'b0;
        in_samples = '0;
        pots = '0;
        for (int b = 0; b < NB; b++) cur_m[b] = 0;

        // reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_rdy", in_rdy, 1);
        check("rst_out_vld", out_vld, 0);
        check("rst_out_sample", $signed(out_sample), 0);
        check("rst_overrun", overrun, 0);
        check("rst_state", dbg_state, 0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // fixed vector table
`ifdef GAIN_SMOOTH_EN
        for (int k = 0; k < 5; k++) begin
            v.s = '{1024, 0, 0, 0}; v.p = '{2048, 0, 0, 0};
            v.exp_v = (k < 4) ? 256 * (k + 1) : 1024;
            vecs.push_back(v);
        end
`else
        v.s = '{1000, 2000, -500, 0};       v.p = '{2048, 2048, 2048, 2048}; v.exp_v = 2500;   vecs.push_back(v);
        v.s = '{1000, 0, 0, 0};             v.p = '{4095, 4095, 4095, 4095}; v.exp_v = 3998;   vecs.push_back(v);
        v.s = '{10000, 10000, 10000, 10000}; v.p = '{4095, 4095, 4095, 4095}; v.exp_v = 32767;  vecs.push_back(v);
        v.s = '{-10000, -10000, -10000, -10000}; v.p = '{4095, 4095, 4095, 4095}; v.exp_v = -32768; vecs.push_back(v);
        v.s = '{32767, 32767, 0, 0};        v.p = '{2048, 2048, 2048, 2048}; v.exp_v = 32767;  vecs.push_back(v);
        v.s = '{12345, -9999, 777, 1};      v.p = '{0, 0, 0, 0};             v.exp_v = 0;      vecs.push_back(v);
        v.s = '{-1, 0, 0, 0};               v.p = '{1024, 0, 0, 0};          v.exp_v = -1;     vecs.push_back(v);
        v.s = '{4000, 100, 0, 0};           v.p = '{1024, 4095, 0, 0};       v.exp_v = 1399;   vecs.push_back(v);
`endif
        for (int i = 0; i < vecs.size(); i++) begin
            ev = model_frame(vecs[i].s, vecs[i].p);
            send_frame(vecs[i].s, vecs[i].p, vecs[i].exp_v[DW-1:0], $sformatf("table%0d", i));
        end

        // overrun during MAC and during OUT
        overrun_frame(2, "ovr_mac");
        overrun_frame(5, "ovr_out");

        // randomized frames against the reference model
        for (int i = 0; i < 40; i++) begin
            for (int b = 0; b < NB; b++) begin
                r = 16'($urandom);
                s[b] = longint'($signed(r));
                case ($urandom_range(0, 3))
                    0:       p[b] = 4095;
                    1:       p[b] = 2048;
                    default: p[b] = $urandom_range(0, 4095);
                endcase
            end
            ev = model_frame(s, p);
            send_frame(s, p, ev[DW-1:0], $sformatf("rand%0d", i));
        end

        // reset in the middle of a frame
        s = '{20000, 20000, 20000, 20000};
        p = '{4095, 4095, 4095, 4095};
        wait_ready();
        in_samples = pack_s(s);
        pots = pack_p(p);
        in_vld = 1'b1;
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int b = 0; b < NB; b++) cur_m[b] = 0;
        #1;
        pulses = 0;
        check("midrst_in_rdy_async", in_rdy, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            if (out_vld) pulses++;
        end
        check("midrst_no_out_vld", pulses, 0);
        check("midrst_in_rdy", in_rdy, 1);
        check("midrst_out_sample", $signed(out_sample), 0);

        // frames after reset still work
        for (int i = 0; i < 4; i++) begin
            for (int b = 0; b < NB; b++) begin
                r = 16'($urandom);
                s[b] = longint'($signed(r));
                p[b] = $urandom_range(0, 4095);
            end
            ev = model_frame(s, p);
            send_frame(s, p, ev[DW-1:0], $sformatf("post_rst%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
